// File: rtl/uart_alu_interface_pkg.sv
// rtl/uart_alu_interface_pkg.sv - shared widths, FSM state encoding and parity helper
//
// Contents:
//   DATA_WIDTH_DEF / OP_WIDTH_DEF / START_HOLD_DEF : default parameter values
//   state_t                                       : 3-bit FSM encoding, WAIT_A=0 .. WAIT_TX=5
//   even_parity()                                 : XOR-reduce of a zero-extended word
package uart_alu_interface_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OP_WIDTH_DEF   = 6;
    localparam int START_HOLD_DEF = 16;

    // Widest word the parity helper accepts; callers zero-extend, which
    // leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_alu_interface_if.sv
// rtl/uart_alu_interface_if.sv - bundle of RX/ALU/TX handshake signals around the ALU endpoint
//
// Signals (direction as seen by the endpoint, modport slave):
//   i_rx_done, i_rx_data, i_rx_parity : byte stream from UART_RX
//   i_alu_result                      : combinational ALU result
//   i_tx_done                         : frame-complete level from UART_TX
//   o_data_a, o_data_b, o_opcode      : registered ALU operands
//   o_tx_start, o_tx_data, o_tx_parity: request to UART_TX
//   o_busy, o_rx_drop                 : status
// Modport master is the environment side (drives the i_* signals).
interface uart_alu_interface_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic                  i_rx_done;
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_parity;
    logic [DATA_WIDTH-1:0] i_alu_result;
    logic                  i_tx_done;
    logic [DATA_WIDTH-1:0] o_data_a;
    logic [DATA_WIDTH-1:0] o_data_b;
    logic [OP_WIDTH-1:0]   o_opcode;
    logic                  o_tx_start;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_parity;
    logic                  o_busy;
    logic                  o_rx_drop;

    modport slave (
        input  i_rx_done, i_rx_data, i_rx_parity, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_opcode, o_tx_start, o_tx_data,
               o_tx_parity, o_busy, o_rx_drop
    );

    modport master (
        output i_rx_done, i_rx_data, i_rx_parity, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_opcode, o_tx_start, o_tx_data,
               o_tx_parity, o_busy, o_rx_drop
    );
endinterface

// File: rtl/uart_alu_interface_edge_detect.sv
// rtl/uart_alu_interface_edge_detect.sv - single-bit rising-edge pulse generator
//
// Ports:
//   i_clock : clock
//   i_reset : synchronous reset, active-low
//   i_sig   : level input (already synchronous to i_clock)
//   o_pulse : high for the one clock where i_sig is 1 and was 0 last clock
module edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_pulse
);
    logic sig_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_pulse = i_sig & ~sig_q;
endmodule

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - collects A, B, opcode bytes from UART_RX, runs the ALU, sends the result to UART_TX
//
// Ports:
//   i_clock : system clock
//   i_reset : synchronous reset, active-low
//   bus     : uart_alu_interface_if.slave (RX byte in, ALU operands/result, TX request, status)
// Optional feature: define PARITY_CHECK_EN to reject received operand/opcode
// bytes whose i_rx_parity disagrees with the even parity of i_rx_data; a
// rejected byte restarts the whole operation from WAIT_A.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OP_WIDTH   = OP_WIDTH_DEF,
    parameter int START_HOLD = START_HOLD_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    uart_alu_interface_if.slave   bus
);
    localparam int HOLD_W = $clog2(START_HOLD + 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] data_a_q;
    logic [DATA_WIDTH-1:0] data_b_q;
    logic [OP_WIDTH-1:0]   opcode_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;
    logic                  rx_drop_q;
    logic [HOLD_W-1:0]     hold_q;

    logic rx_evt;
    logic tx_evt;

    edge_detect u_rx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (bus.i_rx_done),
        .o_pulse (rx_evt)
    );

    edge_detect u_tx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (bus.i_tx_done),
        .o_pulse (tx_evt)
    );

`ifdef PARITY_CHECK_EN
    logic rx_bad;
    assign rx_bad = (bus.i_rx_parity != even_parity(PARITY_MAX_W'(bus.i_rx_data)));
`else
    // Parity from the receiver is accepted but not acted on in this build.
    logic unused_rx_parity;
    assign unused_rx_parity = bus.i_rx_parity;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= ST_WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rx_drop_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            rx_drop_q <= 1'b0;
            case (state_q)
                ST_WAIT_A: begin
                    if (rx_evt) begin
`ifdef PARITY_CHECK_EN
                        if (rx_bad) begin
                            rx_drop_q <= 1'b1;
                            state_q   <= ST_WAIT_A;
                        end else
`endif
                        begin
                            data_a_q <= bus.i_rx_data;
                            state_q  <= ST_WAIT_B;
                        end
                    end
                end
                ST_WAIT_B: begin
                    if (rx_evt) begin
`ifdef PARITY_CHECK_EN
                        if (rx_bad) begin
                            rx_drop_q <= 1'b1;
                            state_q   <= ST_WAIT_A;
                        end else
`endif
                        begin
                            data_b_q <= bus.i_rx_data;
                            state_q  <= ST_WAIT_OP;
                        end
                    end
                end
                ST_WAIT_OP: begin
                    if (rx_evt) begin
`ifdef PARITY_CHECK_EN
                        if (rx_bad) begin
                            rx_drop_q <= 1'b1;
                            state_q   <= ST_WAIT_A;
                        end else
`endif
                        begin
                            opcode_q <= bus.i_rx_data[OP_WIDTH-1:0];
                            state_q  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable for one full clock, so the
                    // combinational ALU output is settled here.
                    tx_data_q  <= bus.i_alu_result;
                    tx_start_q <= 1'b1;
                    hold_q     <= '0;
                    state_q    <= ST_SEND;
                    if (rx_evt) rx_drop_q <= 1'b1;
                end
                ST_SEND: begin
                    // Start is held long enough for the transmitter's baud
                    // tick to see it at least once.
                    if (hold_q == HOLD_W'(START_HOLD - 1)) begin
                        tx_start_q <= 1'b0;
                        state_q    <= ST_WAIT_TX;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                    if (rx_evt) rx_drop_q <= 1'b1;
                end
                ST_WAIT_TX: begin
                    if (rx_evt) rx_drop_q <= 1'b1;
                    if (tx_evt) state_q <= ST_WAIT_A;
                end
                default: begin
                    state_q    <= ST_WAIT_A;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data_a    = data_a_q;
    assign bus.o_data_b    = data_b_q;
    assign bus.o_opcode    = opcode_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_parity = even_parity(PARITY_MAX_W'(tx_data_q));
    assign bus.o_busy      = (state_q != ST_WAIT_A);
    assign bus.o_rx_drop   = rx_drop_q;
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - self-checking bench for uart_alu_interface
module tb_uart_alu_interface;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] sb_q[$];

    uart_alu_interface_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();

    uart_alu_interface #(.DATA_WIDTH(8), .OP_WIDTH(6), .START_HOLD(16)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU driven from the DUT's registered operands.
    always_comb begin
        case (bus.o_opcode)
            6'h20:   bus.i_alu_result = bus.o_data_a + bus.o_data_b;
            6'h22:   bus.i_alu_result = bus.o_data_a - bus.o_data_b;
            6'h24:   bus.i_alu_result = bus.o_data_a & bus.o_data_b;
            6'h25:   bus.i_alu_result = bus.o_data_a | bus.o_data_b;
            6'h26:   bus.i_alu_result = bus.o_data_a ^ bus.o_data_b;
            6'h27:   bus.i_alu_result = ~(bus.o_data_a | bus.o_data_b);
            default: bus.i_alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_byte;
        logic [5:0] op_exp;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte_p(input logic [7:0] d, input logic par, output logic drop);
        @(negedge clk);
        bus.i_rx_data   = d;
        bus.i_rx_parity = par;
        bus.i_rx_done   = 1'b1;
        @(negedge clk);
        drop          = bus.o_rx_drop;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        logic drop;
        send_byte_p(d, ^d, drop);
    endtask

    // Called right after the opcode byte: checks latency, result, parity and hold length.
    task automatic wait_send(input string tag);
        logic [7:0] exp;
        int hi;
        @(negedge clk);
        check({tag, "_tx_start_latency"}, bus.o_tx_start, 1'b1);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 0, 1);
            exp = 8'h00;
        end else begin
            exp = sb_q.pop_front();
        end
        check({tag, "_tx_data"}, bus.o_tx_data, exp);
        check({tag, "_tx_parity"}, bus.o_tx_parity, ^exp);
        hi = bus.o_tx_start ? 1 : 0;
        for (int i = 0; i < 40 && bus.o_tx_start; i++) begin
            @(negedge clk);
            if (bus.o_tx_start) hi++;
        end
        check({tag, "_tx_start_hold"}, hi, 16);
        check({tag, "_busy_wait_tx"}, bus.o_busy, 1'b1);
    endtask

    task automatic tx_complete(input string tag);
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        check({tag, "_busy_after_tx_done"}, bus.o_busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] res);
        send_byte(a);
        send_byte(b);
        sb_q.push_back(res);
        send_byte(op);
        wait_send(tag);
    endtask

    initial begin
        logic drop;
        checks   = 0;
        failures = 0;
        bus.i_rx_done   = 1'b0;
        bus.i_rx_data   = 8'h00;
        bus.i_rx_parity = 1'b0;
        bus.i_tx_done   = 1'b0;
        rst_n           = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        vecs[1] = '{8'hF0, 8'h20, 8'h22, 6'h22, 8'hD0};
        vecs[2] = '{8'hCC, 8'hAA, 8'h24, 6'h24, 8'h88};
        vecs[3] = '{8'hCC, 8'hAA, 8'h25, 6'h25, 8'hEE};
        vecs[4] = '{8'hCC, 8'hAA, 8'h26, 6'h26, 8'h66};
        vecs[5] = '{8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00};
        vecs[6] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
        vecs[7] = '{8'h00, 8'h01, 8'h22, 6'h22, 8'hFF};
        vecs[8] = '{8'h12, 8'h34, 8'hE0, 6'h20, 8'h46};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_data_a", bus.o_data_a, 8'h00);
        check("reset_tx_start", bus.o_tx_start, 1'b0);
        check("reset_tx_data", bus.o_tx_data, 8'h00);
        check("reset_busy", bus.o_busy, 1'b0);
        check("reset_rx_drop", bus.o_rx_drop, 1'b0);

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(tag, vecs[i].a, vecs[i].b, vecs[i].op_byte, vecs[i].res);
            check({tag, "_opcode"}, bus.o_opcode, vecs[i].op_exp);
            check({tag, "_data_a_stable"}, bus.o_data_a, vecs[i].a);
            check({tag, "_data_b_stable"}, bus.o_data_b, vecs[i].b);
            tx_complete(tag);
        end

        // Level-held rx_done counts once; tx_done outside WAIT_TX is ignored.
        @(negedge clk);
        bus.i_rx_data   = 8'h5B;
        bus.i_rx_parity = 1'b1;
        bus.i_rx_done   = 1'b1;
        repeat (50) @(negedge clk);
        bus.i_rx_done = 1'b0;
        check("held_data_a", bus.o_data_a, 8'h5B);
        check("held_busy", bus.o_busy, 1'b1);
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        check("stray_tx_busy", bus.o_busy, 1'b1);
        send_byte(8'h10);
        check("held_data_b", bus.o_data_b, 8'h10);
        check("held_data_a_kept", bus.o_data_a, 8'h5B);
        check("held_no_start", bus.o_tx_start, 1'b0);
        sb_q.push_back(8'h6B);
        send_byte(8'h20);
        wait_send("held");
        tx_complete("held");

        // Byte during TX, then simultaneous rx/tx edges in WAIT_TX.
        run_op("duringtx", 8'h33, 8'h11, 8'h22, 8'h22);
        send_byte_p(8'hAA, 1'b0, drop);
        check("duringtx_drop_pulse", drop, 1'b1);
        @(negedge clk);
        check("duringtx_drop_one_clk", bus.o_rx_drop, 1'b0);
        check("duringtx_data_a_kept", bus.o_data_a, 8'h33);
        check("duringtx_still_busy", bus.o_busy, 1'b1);
        bus.i_rx_data   = 8'h77;
        bus.i_rx_parity = 1'b0;
        bus.i_rx_done   = 1'b1;
        bus.i_tx_done   = 1'b1;
        @(negedge clk);
        check("simul_drop", bus.o_rx_drop, 1'b1);
        check("simul_busy", bus.o_busy, 1'b0);
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        @(negedge clk);
        check("simul_data_a_kept", bus.o_data_a, 8'h33);

        // Reset mid-operation.
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_data_a", bus.o_data_a, 8'h00);
        check("midrst_data_b", bus.o_data_b, 8'h00);
        check("midrst_opcode", bus.o_opcode, 6'h00);
        check("midrst_tx_data", bus.o_tx_data, 8'h00);
        check("midrst_tx_parity", bus.o_tx_parity, 1'b0);
        check("midrst_busy", bus.o_busy, 1'b0);
        run_op("postrst", 8'h01, 8'h02, 8'h22, 8'hFF);
        check("postrst_data_a", bus.o_data_a, 8'h01);
        tx_complete("postrst");

`ifdef PARITY_CHECK_EN
        send_byte(8'h01);
        send_byte_p(8'h5B, 1'b0, drop);
        check("par_bad_drop", drop, 1'b1);
        check("par_bad_restart", bus.o_busy, 1'b0);
        check("par_bad_not_stored", bus.o_data_b, 8'h02);
        send_byte(8'h01);
        send_byte_p(8'h5B, 1'b1, drop);
        check("par_good_no_drop", drop, 1'b0);
        check("par_good_stored", bus.o_data_b, 8'h5B);
        sb_q.push_back(8'h5C);
        send_byte(8'h20);
        wait_send("par");
        tx_complete("par");
`endif

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
Consumer-side endpoint of the serial link. It sits after UART_RX and before UART_TX, and collects three received bytes in order: operand A, operand B, opcode. It presents them to the combinational ALU, captures the result, and hands it back to UART_TX for transmission. It closes the loop that the RX/TX pair currently leaves open at board level.

Parameters:
DATA_WIDTH, 8, operand/result/serial byte width
OP_WIDTH, 6, opcode width; low OP_WIDTH bits of third byte
START_HOLD, 16, clocks o_tx_start is held high (≥ one baud tick period)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous reset, active-low (0 = reset)
i_rx_done  in  1  UART_RX o_done_bit; byte valid on its rising edge
i_rx_data  in  DATA_WIDTH  UART_RX o_data_byte
i_rx_parity  in  1  UART_RX o_parity
i_alu_result  in  DATA_WIDTH  combinational ALU result
i_tx_done  in  1  UART_TX o_done_bit; frame finished on its rising edge
o_data_a  out  DATA_WIDTH  registered operand A to ALU
o_data_b  out  DATA_WIDTH  registered operand B to ALU
o_opcode  out  OP_WIDTH  registered opcode to ALU
o_tx_start  out  1  UART_TX i_tx_signal
o_tx_data  out  DATA_WIDTH  UART_TX i_data_byte, registered result
o_tx_parity  out  1  UART_TX i_parity = XOR-reduce(o_tx_data), even parity
o_busy  out  1  high in any state other than WAIT_A
o_rx_drop  out  1  one-cycle pulse: byte received and discarded

Behaviour:
- Reset: i_reset==0 sampled on posedge i_clock. All outputs go to 0, state goes to WAIT_A, edge-detect registers go to 0, hold counter goes to 0. Reset mid-frame or mid-TX aborts immediately; partial operands are lost.
- Edge detection: rx_evt = i_rx_done & ~i_rx_done_q; tx_evt = i_tx_done & ~i_tx_done_q. Only these edges are acted on. A level held high for many clocks counts once.
- FSM:
  - WAIT_A: on rx_evt, o_data_a <= i_rx_data, go to WAIT_B.
  - WAIT_B: on rx_evt, o_data_b <= i_rx_data, go to WAIT_OP.
  - WAIT_OP: on rx_evt, o_opcode <= i_rx_data[OP_WIDTH-1:0], go to EXEC.
  - EXEC: exactly 1 clock for ALU settle. o_tx_data <= i_alu_result, go to SEND.
  - SEND: o_tx_start=1, counter counts START_HOLD clocks, then o_tx_start=0 and go to WAIT_TX.
  - WAIT_TX: on tx_evt, go to WAIT_A.
- Latency: the result is registered 2 clocks after the opcode rx_evt, and o_tx_start rises in the same clock SEND is entered.
- rx_evt in EXEC, SEND or WAIT_TX: byte discarded, o_rx_drop pulses 1 clock, state unchanged.
- tx_evt outside WAIT_TX: ignored.
- rx_evt and tx_evt in the same clock in WAIT_TX: go to WAIT_A, and the byte is dropped (o_rx_drop=1).
- o_data_a/b and o_opcode hold their value until overwritten, so the ALU output stays stable during TX.

Optional Feature:
Macro: PARITY_CHECK_EN
- Defined: on each rx_evt in WAIT_A, WAIT_B or WAIT_OP, compare i_rx_parity against XOR-reduce(i_rx_data).
  - Mismatch: byte is not stored, state returns to WAIT_A (whole operation restarts), o_rx_drop pulses.
- Not defined: i_rx_parity is ignored (port still present, unused). Every byte is accepted.

Decomposition:
- Shared package uart_pkg: DATA_WIDTH/OP_WIDTH defaults, state encoding localparams (WAIT_A=0 … WAIT_TX=5, 3-bit), even-parity function.
- One natural sub-module, edge_detect (1-bit rising-edge pulse, active-low sync reset), instanced twice for rx_done and tx_done.
- Hold counter and FSM stay in the top.

Test Plan:
- Normal op: RX bytes 0x05, 0x03, 0x20 (ADD), bench ALU returns 0x08 → o_tx_data=0x08, o_tx_parity=1, o_tx_start high exactly 16 clocks, o_busy drops after i_tx_done edge.
- Level-held done: i_rx_done held high 50 clocks with 0x5B → only o_data_a=0x5B loaded, state WAIT_B.
- Byte during TX: send 0xAA while in WAIT_TX → o_rx_drop 1-clock pulse, o_data_a unchanged, state still WAIT_TX.
- Reset mid-op: after A=0x11 and B=0x22, pull i_reset low 1 clock → all outputs 0, next three bytes 0x01, 0x02, 0x22 (SUB) start a fresh operation.
- PARITY_CHECK_EN: byte 0x5B with parity 0 in WAIT_B → o_rx_drop, state WAIT_A. Repeat with parity 1 → accepted.
- Simultaneous: rx_evt and tx_evt in the same clock in WAIT_TX → state WAIT_A, o_rx_drop=1.
